// File: rtl/card_pkg.sv
// Shared definitions for the card-handling blocks: deck geometry, shuffler states,
// LFSR constants and the Fisher-Yates index scaling helper.
package card_pkg;

    localparam int          DECK_SIZE_DEF = 52;
    localparam int          ADDR_W        = 6;
    localparam int          CARD_W        = 7;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_I,
        ST_RD_J,
        ST_CAP_J,
        ST_WR_I,
        ST_WR_J,
        ST_DONE
    } shuf_state_t;

    // Scales r = lfsr[5:0] into 0..i as (r * (i+1)) >> 6. The multiplier is 7 bits
    // because i+1 reaches 64 for a full deck; 63*64 still fits the 12-bit product.
    function automatic logic [ADDR_W-1:0] pick_j(input logic [15:0]       lfsr,
                                                 input logic [ADDR_W-1:0] i);
        logic [ADDR_W:0] n;
        logic [11:0]     p;
        n = {1'b0, i} + 7'd1;
        p = 12'(lfsr[5:0]) * 12'(n);
        return p[11:6];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by the default so the register never locks up.
module lfsr16
    import card_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= LFSR_SEED_DEF;
        end else if (load) begin
            q <= (seed == 16'h0000) ? LFSR_SEED_DEF : seed;
        end else if (step) begin
            q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
        end
    end

endmodule

// File: rtl/deck_shuffler.sv
// In-place Fisher-Yates shuffle of an external synchronous-read deck memory,
// five cycles per swap (read i, read j, capture, write i, write j).
//
// state  | meaning
// IDLE   | waiting for start; memory port owned by the top level
// RD_I   | present address i, register j from the LFSR
// RD_J   | present address j, capture card_i
// CAP_J  | capture card_j
// WR_I   | write card_j to address i
// WR_J   | write card_i to address j, step LFSR, next i or finish
// DONE   | one-cycle done pulse
module deck_shuffler
    import card_pkg::*;
#(
    parameter int DECK_SIZE = DECK_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       seed,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] deck_addr,
    output logic              deck_wen,
    output logic [CARD_W-1:0] deck_data_in,
    input  logic [CARD_W-1:0] deck_data_out
);

    shuf_state_t       state, state_nx;
    logic [ADDR_W-1:0] i_q, j_q;
    logic [CARD_W-1:0] card_i, card_j;
    logic [15:0]       lfsr_q;
    logic              lfsr_load, lfsr_step;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (seed),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            i_q    <= '0;
            j_q    <= '0;
            card_i <= '0;
            card_j <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE:  if (start) i_q <= ADDR_W'(DECK_SIZE - 1);
                ST_RD_I:  j_q <= pick_j(lfsr_q, i_q);
                ST_RD_J:  card_i <= deck_data_out;
                ST_CAP_J: card_j <= deck_data_out;
                ST_WR_J:  if (i_q != ADDR_W'(1)) i_q <= i_q - ADDR_W'(1);
                default:  ;
            endcase
        end
    end

    // Outputs decode from state only, so an async reset clears them at once.
    always_comb begin
        state_nx     = state;
        busy         = 1'b1;
        done         = 1'b0;
        deck_addr    = '0;
        deck_wen     = 1'b0;
        deck_data_in = '0;
        lfsr_load    = 1'b0;
        lfsr_step    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    lfsr_load = 1'b1;
                    state_nx  = ST_RD_I;
                end
            end
            ST_RD_I: begin
                deck_addr = i_q;
                state_nx  = ST_RD_J;
            end
            ST_RD_J: begin
                deck_addr = j_q;
                state_nx  = ST_CAP_J;
            end
            ST_CAP_J: begin
                state_nx = ST_WR_I;
            end
            ST_WR_I: begin
                deck_addr    = i_q;
                deck_data_in = card_j;
                deck_wen     = 1'b1;
                state_nx     = ST_WR_J;
            end
            ST_WR_J: begin
                deck_addr    = j_q;
                deck_data_in = card_i;
                deck_wen     = 1'b1;
                lfsr_step    = 1'b1;
                state_nx     = (i_q == ADDR_W'(1)) ? ST_DONE : ST_RD_I;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler with a behavioural synchronous-read deck memory
// and an independent Fisher-Yates reference model.
module tb_deck_shuffler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0000;
    logic        busy, done, deck_wen;
    logic [5:0]  deck_addr;
    logic [6:0]  deck_data_in, deck_data_out;

    logic [6:0]  mem [64];
    logic [6:0]  rd_q = 7'd0;
    logic        tb_wr = 1'b0;
    logic [5:0]  tb_wa = 6'd0;
    logic [6:0]  tb_wd = 7'd0;
    logic [6:0]  exp_deck [64];
    logic [6:0]  save_deck [64];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_wr) mem[tb_wa] <= tb_wd;
        else if (deck_wen) mem[deck_addr] <= deck_data_in;
        rd_q <= mem[deck_addr];
    end
    assign deck_data_out = rd_q;

    deck_shuffler #(.DECK_SIZE(52)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .deck_addr     (deck_addr),
        .deck_wen      (deck_wen),
        .deck_data_in  (deck_data_in),
        .deck_data_out (deck_data_out)
    );

    task automatic load_deck();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            tb_wr = 1'b1;
            tb_wa = 6'(k);
            tb_wd = (k < 52) ? 7'(k) : 7'd0;
        end
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    // Leaves the bench at the first negedge after acceptance (state RD_I).
    task automatic pulse_start(input logic [15:0] s);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        int c = 1;
        while (done !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        cyc = c;
    endtask

    task automatic model_shuffle(input logic [15:0] s);
        logic [15:0] l;
        logic [6:0]  t;
        int          j;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int k = 0; k < 64; k++) exp_deck[k] = (k < 52) ? 7'(k) : 7'd0;
        for (int i = 51; i >= 1; i--) begin
            j = (int'(l[5:0]) * (i + 1)) / 64;
            t = exp_deck[i];
            exp_deck[i] = exp_deck[j];
            exp_deck[j] = t;
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
        n_cmp++; if (deck_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %0b want 0", deck_wen); end
        n_cmp++; if (deck_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", deck_addr); end
        n_cmp++; if (deck_data_in !== 7'd0) begin n_err++; $display("FAIL reset_din got %0d want 0", deck_data_in); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_first_swap();
        int cyc;
        load_deck();
        pulse_start(16'h0001);
        n_cmp++; if (deck_addr !== 6'd51 || deck_wen !== 1'b0)
            begin n_err++; $display("FAIL first_rd_i got addr=%0d wen=%0b want addr=51 wen=0", deck_addr, deck_wen); end
        @(negedge clk);
        n_cmp++; if (deck_addr !== 6'd0)
            begin n_err++; $display("FAIL first_rd_j got addr=%0d want 0", deck_addr); end
        repeat (2) @(negedge clk);
        n_cmp++; if (deck_addr !== 6'd51 || deck_wen !== 1'b1 || deck_data_in !== 7'd0)
            begin n_err++; $display("FAIL first_wr_i got addr=%0d wen=%0b din=%0d want 51 1 0", deck_addr, deck_wen, deck_data_in); end
        @(negedge clk);
        n_cmp++; if (deck_addr !== 6'd0 || deck_wen !== 1'b1 || deck_data_in !== 7'd51)
            begin n_err++; $display("FAIL first_wr_j got addr=%0d wen=%0b din=%0d want 0 1 51", deck_addr, deck_wen, deck_data_in); end
        @(negedge clk);
        n_cmp++; if (mem[51] !== 7'd0 || mem[0] !== 7'd51)
            begin n_err++; $display("FAIL first_swap_mem got m51=%0d m0=%0d want 0 51", mem[51], mem[0]); end
        wait_done(cyc);
        @(negedge clk);
    endtask

    task automatic test_j_equals_i();
        int cyc;
        load_deck();
        pulse_start(16'h003F);
        @(negedge clk);
        n_cmp++; if (deck_addr !== 6'd51)
            begin n_err++; $display("FAIL jeqi_rd_j got addr=%0d want 51", deck_addr); end
        repeat (2) @(negedge clk);
        n_cmp++; if (deck_addr !== 6'd51 || deck_wen !== 1'b1 || deck_data_in !== 7'd51)
            begin n_err++; $display("FAIL jeqi_wr_i got addr=%0d wen=%0b din=%0d want 51 1 51", deck_addr, deck_wen, deck_data_in); end
        @(negedge clk);
        n_cmp++; if (deck_addr !== 6'd51 || deck_wen !== 1'b1 || deck_data_in !== 7'd51)
            begin n_err++; $display("FAIL jeqi_wr_j got addr=%0d wen=%0b din=%0d want 51 1 51", deck_addr, deck_wen, deck_data_in); end
        @(negedge clk);
        n_cmp++; if (mem[51] !== 7'd51)
            begin n_err++; $display("FAIL jeqi_mem got %0d want 51", mem[51]); end
        wait_done(cyc);
        @(negedge clk);
    endtask

    task automatic check_result(input logic [15:0] s, input string tag);
        logic [63:0] seen;
        int          bad;
        seen = '0;
        bad  = 0;
        for (int k = 0; k < 52; k++) begin
            if (mem[k] < 7'd52) seen[mem[k]] = 1'b1;
        end
        n_cmp++; if (seen[51:0] !== {52{1'b1}})
            begin n_err++; $display("FAIL %s_perm got seen=%h want all 52 values", tag, seen); end
        model_shuffle(s);
        for (int k = 0; k < 52; k++) if (mem[k] !== exp_deck[k]) bad++;
        n_cmp++; if (bad != 0)
            begin n_err++; $display("FAIL %s_model got %0d differing entries want 0", tag, bad); end
    endtask

    task automatic test_full(input logic [15:0] s, input string tag);
        int cyc;
        load_deck();
        pulse_start(s);
        wait_done(cyc);
        n_cmp++; if (cyc != 256)
            begin n_err++; $display("FAIL %s_latency got %0d want 256", tag, cyc); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL %s_done_pulse got done=%0b busy=%0b want 0 0", tag, done, busy); end
        check_result(s, tag);
    endtask

    task automatic test_seed_zero();
        int bad = 0;
        test_full(16'h0000, "seed0");
        for (int k = 0; k < 64; k++) save_deck[k] = mem[k];
        test_full(16'hACE1, "aceseed");
        for (int k = 0; k < 52; k++) if (save_deck[k] !== mem[k]) bad++;
        n_cmp++; if (bad != 0)
            begin n_err++; $display("FAIL seed0_vs_ace1 got %0d differing entries want 0", bad); end
    endtask

    task automatic test_start_while_busy();
        int c = 1;
        load_deck();
        pulse_start(16'h1234);
        while (done !== 1'b1 && c < 400) begin
            if (c == 100) begin start = 1'b1; seed = 16'h5555; end
            else start = 1'b0;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        n_cmp++; if (c != 256)
            begin n_err++; $display("FAIL busy_start_latency got %0d want 256", c); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)
            begin n_err++; $display("FAIL busy_start_restart got busy=%0b want 0", busy); end
        check_result(16'h1234, "busy_start");
    endtask

    task automatic test_reset_mid();
        int cyc;
        load_deck();
        pulse_start(16'h0007);
        repeat (3) @(negedge clk);
        n_cmp++; if (deck_wen !== 1'b1)
            begin n_err++; $display("FAIL midrst_in_wr_i got wen=%0b want 1", deck_wen); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({busy, done, deck_wen} !== 3'b000 || deck_addr !== 6'd0 || deck_data_in !== 7'd0)
            begin n_err++; $display("FAIL midrst_outputs got busy=%0b done=%0b wen=%0b addr=%0d din=%0d want all 0",
                                    busy, done, deck_wen, deck_addr, deck_data_in); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)
            begin n_err++; $display("FAIL midrst_idle got busy=%0b want 0", busy); end
        test_full(16'h0007, "midrst_rerun");
    endtask

    initial begin
        test_reset();
        test_first_swap();
        test_j_equals_i();
        test_full(16'h0001, "seed1");
        test_full(16'hBEEF, "seedbeef");
        test_seed_zero();
        test_start_while_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
